// File: rtl/neopix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neopix_pkg
// Brief    : Shared types and constants for the NEOPIX hue-wheel generator.
// Revision : 1.0 - initial release
// ============================================================================
package neopix_pkg;

    typedef enum logic [2:0] {
        SEG_R_G_UP   = 3'd0,
        SEG_R_G_DOWN = 3'd1,
        SEG_G_B_UP   = 3'd2,
        SEG_G_B_DOWN = 3'd3,
        SEG_B_R_UP   = 3'd4,
        SEG_M_B_DOWN = 3'd5
    } seg_e;

    localparam int c_G_MSB = 23;
    localparam int c_G_LSB = 16;
    localparam int c_R_MSB = 15;
    localparam int c_R_LSB = 8;
    localparam int c_B_MSB = 7;
    localparam int c_B_LSB = 0;

    localparam int c_DEF_PRESCALE  = 62_500;
    localparam int c_DEF_MAX_LEVEL = 128;

    function automatic seg_e seg_next(input seg_e s);
        return (s == SEG_M_B_DOWN) ? SEG_R_G_UP : seg_e'(s + 3'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/neopix_scale.sv
`default_nettype none
// ============================================================================
// Module   : neopix_scale
// Brief    : One channel brightness scale, level * (scale+1) >> 8, combinational.
// Revision : 1.0 - initial release
// ============================================================================
module neopix_scale (
    input  logic [7:0] i_level,
    input  logic [7:0] i_scale,
    output logic [7:0] o_scaled
);

    logic [8:0]  w_gain;
    logic [16:0] w_prod;
    logic        w_unused_top;
    logic [7:0]  w_unused_frac;

    assign w_gain = {1'b0, i_scale} + 9'd1;
    assign w_prod = {9'd0, i_level} * {8'd0, w_gain};
    // Truncation only: the result can never exceed the input level.
    assign {w_unused_top, o_scaled, w_unused_frac} = w_prod;

endmodule
`default_nettype wire

// File: rtl/neopix_hue_wheel.sv
`default_nettype none
// ============================================================================
// Module   : neopix_hue_wheel
// Brief    : 6-segment rainbow sweep with brightness scale feeding a NEOPIX driver.
// Revision : 1.0 - initial release
// ============================================================================
module neopix_hue_wheel
    import neopix_pkg::*;
#(
    parameter int PRESCALE  = c_DEF_PRESCALE,
    parameter int MAX_LEVEL = c_DEF_MAX_LEVEL
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        EN,
    input  logic        RESTART,
    input  logic [7:0]  SCALE,
    output logic [23:0] GRB,
    output logic [2:0]  SEG,
    output logic        STEP_STB
);

    localparam int             c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);
    localparam logic [7:0]     c_M        = 8'(MAX_LEVEL);
    localparam logic [7:0]     c_R_LAST   = 8'(MAX_LEVEL - 1);

    logic [c_PW-1:0] r_presc;
    logic [7:0]      r_ramp;
    seg_e            r_seg;
    logic            r_tick_d;
    logic            r_stb;
    logic [23:0]     r_grb;

    logic            w_tick;
    logic [7:0]      w_down;
    logic [23:0]     w_lvl;
    logic [23:0]     w_scaled;

    assign w_tick = EN && (r_presc == c_PRE_LAST);
    assign w_down = c_M - r_ramp;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
            r_ramp  <= '0;
            r_seg   <= SEG_R_G_UP;
        end else if (RESTART) begin
            r_presc <= '0;
            r_ramp  <= '0;
            r_seg   <= SEG_R_G_UP;
        end else if (w_tick) begin
            r_presc <= '0;
            if (r_ramp == c_R_LAST) begin
                r_ramp <= '0;
                r_seg  <= seg_next(r_seg);
            end else begin
                r_ramp <= r_ramp + 8'd1;
            end
        end else if (EN) begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    always_comb begin
        w_lvl = '0;
        case (r_seg)
            SEG_R_G_UP: begin
                w_lvl[c_R_MSB:c_R_LSB] = c_M;
                w_lvl[c_G_MSB:c_G_LSB] = r_ramp;
            end
            SEG_R_G_DOWN: begin
                w_lvl[c_R_MSB:c_R_LSB] = w_down;
                w_lvl[c_G_MSB:c_G_LSB] = c_M;
            end
            SEG_G_B_UP: begin
                w_lvl[c_G_MSB:c_G_LSB] = c_M;
                w_lvl[c_B_MSB:c_B_LSB] = r_ramp;
            end
            SEG_G_B_DOWN: begin
                w_lvl[c_G_MSB:c_G_LSB] = w_down;
                w_lvl[c_B_MSB:c_B_LSB] = c_M;
            end
            SEG_B_R_UP: begin
                w_lvl[c_R_MSB:c_R_LSB] = r_ramp;
                w_lvl[c_B_MSB:c_B_LSB] = c_M;
            end
            SEG_M_B_DOWN: begin
                w_lvl[c_R_MSB:c_R_LSB] = c_M;
                w_lvl[c_B_MSB:c_B_LSB] = w_down;
            end
            default: w_lvl = '0;
        endcase
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        neopix_scale u_scale (
            .i_level  (w_lvl[8*i +: 8]),
            .i_scale  (SCALE),
            .o_scaled (w_scaled[8*i +: 8])
        );
    end

    // The strobe trails the tick by two edges so it lands with the first GRB of the new step.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tick_d <= 1'b0;
            r_stb    <= 1'b0;
            r_grb    <= '0;
        end else begin
            r_tick_d <= w_tick && !RESTART;
            r_stb    <= r_tick_d;
            r_grb    <= w_scaled;
        end
    end

    assign GRB      = r_grb;
    assign SEG      = r_seg;
    assign STEP_STB = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_neopix_hue_wheel.sv
`default_nettype none
// ============================================================================
// Module   : tb_neopix_hue_wheel
// Brief    : Self-checking bench for neopix_hue_wheel against a step-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neopix_hue_wheel;

    localparam int P   = 4;
    localparam int M   = 128;
    localparam int REV = 6 * M;

    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b0;
    logic        EN      = 1'b0;
    logic        RESTART = 1'b0;
    logic [7:0]  SCALE   = 8'd255;
    logic [23:0] GRB;
    logic [2:0]  SEG;
    logic        STEP_STB;

    int n_checks = 0;
    int n_pass   = 0;
    int stb_count = 0;

    neopix_hue_wheel #(.PRESCALE(P), .MAX_LEVEL(M)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .EN       (EN),
        .RESTART  (RESTART),
        .SCALE    (SCALE),
        .GRB      (GRB),
        .SEG      (SEG),
        .STEP_STB (STEP_STB)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] sc(input int lvl, input int s);
        return 8'((lvl * (s + 1)) / 256);
    endfunction

    // Colour of wheel position n (0..REV-1) as the hue table describes it.
    function automatic logic [23:0] colour(input int n, input int s);
        int seg = n / M;
        int r   = n % M;
        int cr = 0, cg = 0, cb = 0;
        case (seg)
            0: begin cr = M;     cg = r;     cb = 0;     end
            1: begin cr = M - r; cg = M;     cb = 0;     end
            2: begin cr = 0;     cg = M;     cb = r;     end
            3: begin cr = 0;     cg = M - r; cb = M;     end
            4: begin cr = r;     cg = 0;     cb = M;     end
            default: begin cr = M; cg = 0;   cb = M - r; end
        endcase
        return {sc(cg, s), sc(cr, s), sc(cb, s)};
    endfunction

    int          m_presc;
    int          m_step;
    logic        m_tickd;
    logic [23:0] m_grb;
    logic        m_stb;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_presc <= 0;
            m_step  <= 0;
            m_tickd <= 1'b0;
            m_grb   <= '0;
            m_stb   <= 1'b0;
        end else begin
            m_grb <= colour(m_step, int'(SCALE));
            m_stb <= m_tickd;
            if (RESTART) begin
                m_presc <= 0;
                m_step  <= 0;
                m_tickd <= 1'b0;
            end else begin
                m_tickd <= EN && (m_presc == P - 1);
                if (EN) begin
                    if (m_presc == P - 1) begin
                        m_presc <= 0;
                        m_step  <= (m_step + 1) % REV;
                    end else begin
                        m_presc <= m_presc + 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET_N) begin
            stb_count <= 0;
        end else begin
            check("grb_model", 32'(GRB), 32'(m_grb));
            check("seg_model", 32'(SEG), 32'(m_step / M));
            check("stb_model", 32'(STEP_STB), 32'(m_stb));
            if (STEP_STB) stb_count <= stb_count + 1;
        end
    end

    task automatic wait_stb(input int n, input string name);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < n * P + 50) begin
            @(negedge CLK);
            cyc++;
            if (STEP_STB) got++;
        end
        check({name, "_stb_wait"}, got, n);
    endtask

    task automatic cycles_to_stb(output int cyc);
        cyc = 0;
        while (STEP_STB !== 1'b1 && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    initial begin
        int cyc;

        RESET_N = 1'b0;
        EN      = 1'b1;
        SCALE   = 8'd255;
        repeat (3) @(negedge CLK);
        check("reset_grb", 32'(GRB), 32'h0);
        check("reset_seg", 32'(SEG), 32'd0);
        check("reset_stb", 32'(STEP_STB), 32'd0);

        RESET_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("grb_2nd_edge", 32'(GRB), 32'h008000);
        cycles_to_stb(cyc);
        check("first_stb_cycle", cyc + 2, 5);
        check("first_stb_grb", 32'(GRB), 32'h018000);

        wait_stb(127, "to128");
        check("seg1_seg", 32'(SEG), 32'd1);
        check("seg1_grb", 32'(GRB), 32'h808000);
        wait_stb(256, "to384");
        check("seg3_seg", 32'(SEG), 32'd3);
        check("seg3_grb", 32'(GRB), 32'h800080);
        wait_stb(384, "to768");
        check("wrap_seg", 32'(SEG), 32'd0);
        check("wrap_grb", 32'(GRB), 32'h008000);
        #1;
        check("stb_count_768", stb_count, 768);

        wait_stb(320, "to_seg2_mid");
        check("seg2_mid_grb", 32'(GRB), 32'h800040);
        @(negedge CLK);
        EN = 1'b0;
        repeat (50) @(negedge CLK);
        check("freeze_grb", 32'(GRB), 32'h800040);
        check("freeze_seg", 32'(SEG), 32'd2);
        #1;
        check("freeze_stb_count", stb_count, 1088);
        @(negedge CLK);
        EN = 1'b1;
        cycles_to_stb(cyc);
        check("resume_latency", cyc, 3);
        check("resume_grb", 32'(GRB), 32'h800041);

        wait_stb(191, "to_seg4");
        check("seg4_seg", 32'(SEG), 32'd4);
        check("seg4_grb", 32'(GRB), 32'h000080);
        cyc = 0;
        while (m_presc != P - 1 && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        check("tick_align", m_presc, P - 1);
        RESTART = 1'b1;
        @(negedge CLK);
        RESTART = 1'b0;
        check("restart_seg", 32'(SEG), 32'd0);
        check("restart_stb0", 32'(STEP_STB), 32'd0);
        @(negedge CLK);
        check("restart_grb", 32'(GRB), 32'h008000);
        check("restart_stb1", 32'(STEP_STB), 32'd0);

        repeat (4000) begin
            @(negedge CLK);
            EN      = ($urandom_range(0, 7) != 0);
            RESTART = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 15) == 0) SCALE = 8'($urandom);
        end
        EN      = 1'b1;
        RESTART = 1'b0;

        @(negedge CLK);
        RESET_N = 1'b0;
        SCALE   = 8'd127;
        EN      = 1'b0;
        @(negedge CLK);
        check("reset2_grb", 32'(GRB), 32'h0);
        RESET_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("scale127_grb", 32'(GRB), 32'h004000);
        SCALE = 8'd0;
        @(negedge CLK);
        check("scale0_grb", 32'(GRB), 32'h000000);
        SCALE = 8'd200;
        EN    = 1'b1;
        repeat (300) @(negedge CLK);
        check("prereset_grb", 32'(GRB), 32'(colour(75, 200)));
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_rst_grb", 32'(GRB), 32'h0);
        check("async_rst_seg", 32'(SEG), 32'd0);
        check("async_rst_stb", 32'(STEP_STB), 32'd0);

        #10;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
